// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the register file's single write port between the ALU and the
//   load unit. Each source owns a one-entry holding slot (valid/ready). An
//   arbiter drains one slot per cycle onto registered rf_* outputs that feed
//   the register-file write port directly. Writes to x0 are granted and
//   drained, but rf_wren stays inactive for them.
//
//   Build option: define WB_RR_EN for round-robin priority between
//   different-rd entries. When it is undefined, the load slot has fixed
//   priority over the ALU slot.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            asynchronous active-low reset
//   alu_valid/ready/rd/data   ALU writeback handshake and payload
//   ld_valid/ready/rd/data    load writeback handshake and payload
//   rf_wren        register-file write enable, active low (0 = write)
//   rf_rd_addr     register-file write address
//   rf_data        register-file write data
//   rf_is_load     1 = current write comes from the load slot
//   busy           either slot occupied
//   stat_conflict  saturating count of cycles with both slots occupied
module rf_wb_arbiter #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [AW-1:0]   ld_rd,
   input  logic [XLEN-1:0] ld_data,
   output logic            rf_wren,
   output logic [AW-1:0]   rf_rd_addr,
   output logic [XLEN-1:0] rf_data,
   output logic            rf_is_load,
   output logic            busy,
   output logic [7:0]      stat_conflict
);

   logic            slot_alu_v_r;
   logic [AW-1:0]   slot_alu_rd_r;
   logic [XLEN-1:0] slot_alu_data_r;
   logic            slot_ld_v_r;
   logic [AW-1:0]   slot_ld_rd_r;
   logic [XLEN-1:0] slot_ld_data_r;
   logic            alu_older_r;
   logic            ld_older_r;
`ifdef WB_RR_EN
   logic            rr_ld_first_r;
`endif

   logic            rd_eq_s;
   logic            grant_alu_s;
   logic            grant_ld_s;
   logic            alu_fill_s;
   logic            ld_fill_s;
   logic            alu_keep_s;
   logic            ld_keep_s;
   logic [AW-1:0]   sel_rd_s;
   logic [XLEN-1:0] sel_data_s;

   assign rd_eq_s = (slot_alu_rd_r == slot_ld_rd_r);

   // Grant selection from slot state only, so ready never depends on valid.
   always_comb begin
      grant_alu_s = 1'b0;
      grant_ld_s  = 1'b0;
      if (slot_alu_v_r && slot_ld_v_r) begin
         if (rd_eq_s) begin
            // Same destination: preserve program order; ties go to ALU.
            if (ld_older_r) begin
               grant_ld_s = 1'b1;
            end else begin
               grant_alu_s = 1'b1;
            end
         end else begin
`ifdef WB_RR_EN
            if (rr_ld_first_r) begin
               grant_ld_s = 1'b1;
            end else begin
               grant_alu_s = 1'b1;
            end
`else
            grant_ld_s = 1'b1;
`endif
         end
      end else if (slot_alu_v_r) begin
         grant_alu_s = 1'b1;
      end else if (slot_ld_v_r) begin
         grant_ld_s = 1'b1;
      end else begin
         grant_alu_s = 1'b0;
         grant_ld_s  = 1'b0;
      end
   end

   // A slot can take a new entry when empty or when draining this cycle.
   assign alu_ready  = ~slot_alu_v_r | grant_alu_s;
   assign ld_ready   = ~slot_ld_v_r | grant_ld_s;
   assign alu_fill_s = alu_valid & alu_ready;
   assign ld_fill_s  = ld_valid & ld_ready;
   // Occupied now and still occupied after the edge without a refill.
   assign alu_keep_s = slot_alu_v_r & ~grant_alu_s;
   assign ld_keep_s  = slot_ld_v_r & ~grant_ld_s;
   assign busy       = slot_alu_v_r | slot_ld_v_r;

   // Write-port source mux driven by the active grant.
   always_comb begin
      if (grant_ld_s) begin
         sel_rd_s   = slot_ld_rd_r;
         sel_data_s = slot_ld_data_r;
      end else begin
         sel_rd_s   = slot_alu_rd_r;
         sel_data_s = slot_alu_data_r;
      end
   end

   // Holding slots: fill on handshake, otherwise clear when drained.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_alu_v_r    <= 1'b0;
         slot_alu_rd_r   <= {AW{1'b0}};
         slot_alu_data_r <= {XLEN{1'b0}};
         slot_ld_v_r     <= 1'b0;
         slot_ld_rd_r    <= {AW{1'b0}};
         slot_ld_data_r  <= {XLEN{1'b0}};
      end else begin
         if (alu_fill_s) begin
            slot_alu_v_r    <= 1'b1;
            slot_alu_rd_r   <= alu_rd;
            slot_alu_data_r <= alu_data;
         end else if (grant_alu_s) begin
            slot_alu_v_r <= 1'b0;
         end else begin
            slot_alu_v_r <= slot_alu_v_r;
         end
         if (ld_fill_s) begin
            slot_ld_v_r    <= 1'b1;
            slot_ld_rd_r   <= ld_rd;
            slot_ld_data_r <= ld_data;
         end else if (grant_ld_s) begin
            slot_ld_v_r <= 1'b0;
         end else begin
            slot_ld_v_r <= slot_ld_v_r;
         end
      end
   end

   // Age flags: the slot left waiting while the other fills becomes older.
   // Keep and fill are exclusive per slot, since a held slot is not ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_older_r <= 1'b0;
         ld_older_r  <= 1'b0;
      end else if (alu_fill_s && ld_keep_s) begin
         alu_older_r <= 1'b0;
         ld_older_r  <= 1'b1;
      end else if (ld_fill_s && alu_keep_s) begin
         alu_older_r <= 1'b1;
         ld_older_r  <= 1'b0;
      end else if (alu_fill_s || ld_fill_s) begin
         alu_older_r <= 1'b0;
         ld_older_r  <= 1'b0;
      end else begin
         alu_older_r <= alu_older_r;
         ld_older_r  <= ld_older_r;
      end
   end

`ifdef WB_RR_EN
   // Round-robin pointer: after a contended different-rd grant, favour the loser.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ld_first_r <= 1'b0;
      end else if (slot_alu_v_r && slot_ld_v_r && !rd_eq_s) begin
         rr_ld_first_r <= grant_alu_s;
      end else begin
         rr_ld_first_r <= rr_ld_first_r;
      end
   end
`endif

   // Registered write port; an x0 entry drains with the enable held inactive.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_wren    <= 1'b1;
         rf_rd_addr <= {AW{1'b0}};
         rf_data    <= {XLEN{1'b0}};
         rf_is_load <= 1'b0;
      end else if (grant_alu_s || grant_ld_s) begin
         rf_wren    <= (sel_rd_s == {AW{1'b0}});
         rf_rd_addr <= sel_rd_s;
         rf_data    <= sel_data_s;
         rf_is_load <= grant_ld_s;
      end else begin
         rf_wren    <= 1'b1;
         rf_rd_addr <= rf_rd_addr;
         rf_data    <= rf_data;
         rf_is_load <= rf_is_load;
      end
   end

   // Conflict statistic: cycles with both slots occupied, saturating.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_conflict <= 8'h00;
      end else if (slot_alu_v_r && slot_ld_v_r && (stat_conflict != 8'hFF)) begin
         stat_conflict <= stat_conflict + 8'h01;
      end else begin
         stat_conflict <= stat_conflict;
      end
   end

endmodule
